// File: rtl/fp_csr_pkg.sv
// ---------------------------------------------------------------------------
// fp_csr_pkg
// Shared definitions for the floating-point CSR access sequencer:
//   - CSR addresses of fflags / frm / fcsr
//   - Zicsr funct3 encodings
//   - CSR port operation encodings (write / set / clear)
//   - sequencer state enum
//   - helper that recognises the FP CSR addresses
// ---------------------------------------------------------------------------
package fp_csr_pkg;

  // FP CSR addresses
  localparam logic [11:0] CSR_FFLAGS = 12'h001;
  localparam logic [11:0] CSR_FRM    = 12'h002;
  localparam logic [11:0] CSR_FCSR   = 12'h003;

  // Zicsr funct3 encodings (000 and 100 are not CSR accesses)
  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  // Operation applied by the CSR port to the addressed register
  typedef enum logic [1:0] {
    CSR_OP_WRITE = 2'b00,
    CSR_OP_SET   = 2'b01,
    CSR_OP_CLEAR = 2'b10
  } csr_op_e;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_ACCESS = 2'b10,
    ST_RESP   = 2'b11
  } seq_state_e;

  // True for the three addresses this port serves
  function automatic logic is_fp_csr_addr(input logic [11:0] addr);
    return (addr == CSR_FFLAGS) || (addr == CSR_FRM) || (addr == CSR_FCSR);
  endfunction

endpackage

// File: rtl/fp_csr_sequencer_if.sv
// ---------------------------------------------------------------------------
// fp_csr_sequencer_if
// Bundles every non-clock/reset signal of the FP CSR sequencer:
//   request channel   : req_valid/req_ready, funct3, addr, rs1 data, zimm,
//                       src_zero (rs1 index or zimm is zero)
//   FPU coupling      : fpu_busy in, fpu_issue_block out
//   CSR port          : csr_write, csr_addr, csr_wdata, csr_op out,
//                       csr_rdata in (combinational read of csr_addr)
//   response channel  : resp_valid/resp_ready, resp_rdata, resp_err
// Modport master is the sequencer (initiator of CSR accesses); modport
// slave is the surrounding pipeline / CSR register file side.
// ---------------------------------------------------------------------------
interface fp_csr_sequencer_if;

  // request from execute-stage CSR dispatch
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [11:0] req_addr;
  logic [31:0] req_rs1_data;
  logic [4:0]  req_zimm;
  logic        req_src_zero;

  // FPU coupling
  logic        fpu_busy;
  logic        fpu_issue_block;

  // CSR register file port
  logic        csr_write;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [1:0]  csr_op;
  logic [31:0] csr_rdata;

  // response to writeback
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    input  req_valid, req_funct3, req_addr, req_rs1_data, req_zimm, req_src_zero,
    output req_ready,
    input  fpu_busy,
    output fpu_issue_block,
    output csr_write, csr_addr, csr_wdata, csr_op,
    input  csr_rdata,
    output resp_valid, resp_rdata, resp_err,
    input  resp_ready
  );

  modport slave (
    output req_valid, req_funct3, req_addr, req_rs1_data, req_zimm, req_src_zero,
    input  req_ready,
    output fpu_busy,
    input  fpu_issue_block,
    input  csr_write, csr_addr, csr_wdata, csr_op,
    output csr_rdata,
    input  resp_valid, resp_rdata, resp_err,
    output resp_ready
  );

endinterface

// File: rtl/fp_csr_req_decode.sv
// ---------------------------------------------------------------------------
// fp_csr_req_decode
// Combinational decode of a Zicsr request targeting the FP CSRs.
// Ports:
//   i_funct3    in  3   Zicsr funct3
//   i_addr      in  12  CSR address
//   i_src_zero  in  1   rs1 index / zimm is zero (suppresses set/clear write)
//   i_rs1_data  in  32  rs1 value for register forms
//   i_zimm      in  5   immediate for immediate forms
//   o_op        out 2   CSR port operation
//   o_wdata     out 32  write/mask data
//   o_wen       out 1   the access really writes the CSR
//   o_illegal   out 1   funct3 or address not served by this port
// ---------------------------------------------------------------------------
module fp_csr_req_decode
  import fp_csr_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [11:0] i_addr,
  input  logic        i_src_zero,
  input  logic [31:0] i_rs1_data,
  input  logic [4:0]  i_zimm,
  output csr_op_e     o_op,
  output logic [31:0] o_wdata,
  output logic        o_wen,
  output logic        o_illegal
);

  logic w_bad_funct3;
  logic w_imm_form;

  // funct3[2] distinguishes the immediate forms from the register forms
  assign w_imm_form = i_funct3[2];

  always_comb begin
    o_op         = CSR_OP_WRITE;
    w_bad_funct3 = 1'b0;
    case (i_funct3)
      F3_CSRRW, F3_CSRRWI: o_op = CSR_OP_WRITE;
      F3_CSRRS, F3_CSRRSI: o_op = CSR_OP_SET;
      F3_CSRRC, F3_CSRRCI: o_op = CSR_OP_CLEAR;
      default:             w_bad_funct3 = 1'b1;
    endcase
  end

  assign o_illegal = w_bad_funct3 || !is_fp_csr_addr(i_addr);

  // A set/clear with x0 / zimm=0 is a pure read and must not write,
  // otherwise the write could clobber concurrently accrued flags.
  assign o_wen = (o_op == CSR_OP_WRITE) || !i_src_zero;

  assign o_wdata = w_imm_form ? {27'b0, i_zimm} : i_rs1_data;

endmodule

// File: rtl/fp_csr_sequencer.sv
// ---------------------------------------------------------------------------
// fp_csr_sequencer
// Initiator side of the FP CSR access port. Accepts one Zicsr request for
// fflags/frm/fcsr, waits for in-flight FPU operations to retire so the
// sticky flags are current (blocking new FPU issue meanwhile), performs a
// single read-modify-write cycle on the CSR port and returns the old value.
// Parameters:
//   DRAIN_MAX  maximum DRAIN cycles before the access is aborted with error
// Ports:
//   clk   in  clock, rising edge
//   rst   in  asynchronous active-high reset
//   bus   master modport of fp_csr_sequencer_if (request, FPU coupling,
//         CSR port and response channels)
// ---------------------------------------------------------------------------
module fp_csr_sequencer
  import fp_csr_pkg::*;
#(
  parameter int DRAIN_MAX = 64
) (
  input  logic               clk,
  input  logic               rst,
  fp_csr_sequencer_if.master bus
);

  localparam int CNT_W = $clog2(DRAIN_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DRAIN_MAX);

  // decode of the incoming request
  csr_op_e     w_op;
  logic [31:0] w_wdata;
  logic        w_wen;
  logic        w_illegal;
  logic [CNT_W-1:0] w_cnt_inc;

  // captured request
  seq_state_e  r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [11:0] r_addr;
  csr_op_e     r_op;
  logic [31:0] r_wdata;
  logic        r_wen;

  // registered outputs
  logic        r_req_ready;
  logic        r_block;
  logic        r_csr_write;
  logic [11:0] r_csr_addr;
  logic [31:0] r_csr_wdata;
  csr_op_e     r_csr_op;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;

  fp_csr_req_decode u_decode (
    .i_funct3   (bus.req_funct3),
    .i_addr     (bus.req_addr),
    .i_src_zero (bus.req_src_zero),
    .i_rs1_data (bus.req_rs1_data),
    .i_zimm     (bus.req_zimm),
    .o_op       (w_op),
    .o_wdata    (w_wdata),
    .o_wen      (w_wen),
    .o_illegal  (w_illegal)
  );

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_op         <= CSR_OP_WRITE;
      r_wdata      <= '0;
      r_wen        <= 1'b0;
      r_req_ready  <= 1'b1;
      r_block      <= 1'b0;
      r_csr_write  <= 1'b0;
      r_csr_addr   <= '0;
      r_csr_wdata  <= '0;
      r_csr_op     <= CSR_OP_WRITE;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_addr      <= bus.req_addr;
            r_op        <= w_op;
            r_wdata     <= w_wdata;
            r_wen       <= w_wen;
            r_req_ready <= 1'b0;
            r_block     <= 1'b1;
            if (w_illegal) begin
              // nothing to drain: answer with an error right away
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
            end else begin
              r_state <= ST_DRAIN;
              r_cnt   <= '0;
            end
          end
        end

        ST_DRAIN: begin
          r_cnt <= w_cnt_inc;
          if (!bus.fpu_busy) begin
            // CSR port outputs only change here, so they hold their
            // values between accesses
            r_state     <= ST_ACCESS;
            r_csr_write <= r_wen;
            r_csr_addr  <= r_addr;
            r_csr_wdata <= r_wdata;
            r_csr_op    <= r_op;
          end else if (w_cnt_inc == CNT_LIMIT) begin
            // FPU never went quiet: abort without touching the CSR
            r_state      <= ST_RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
            r_resp_rdata <= '0;
          end
        end

        ST_ACCESS: begin
          // csr_rdata is the pre-write value during the access cycle
          r_csr_write  <= 1'b0;
          r_resp_rdata <= bus.csr_rdata;
          r_resp_err   <= 1'b0;
          r_resp_valid <= 1'b1;
          r_state      <= ST_RESP;
        end

        ST_RESP: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_block      <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end

        default: begin
          r_state      <= ST_IDLE;
          r_req_ready  <= 1'b1;
          r_block      <= 1'b0;
          r_csr_write  <= 1'b0;
          r_resp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready       = r_req_ready;
  assign bus.fpu_issue_block = r_block;
  assign bus.csr_write       = r_csr_write;
  assign bus.csr_addr        = r_csr_addr;
  assign bus.csr_wdata       = r_csr_wdata;
  assign bus.csr_op          = r_csr_op;
  assign bus.resp_valid      = r_resp_valid;
  assign bus.resp_rdata      = r_resp_rdata;
  assign bus.resp_err        = r_resp_err;

endmodule
